// File: rtl/usb_pkg.sv
// Shared USB definitions: handshake encoding toward the protocol engine and PID nibbles.
package usb_pkg;

  typedef enum logic [1:0] {
    hs_ack   = 2'b00,
    hs_none  = 2'b01,
    hs_nak   = 2'b10,
    hs_stall = 2'b11
  } handshake_t;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

endpackage

// File: rtl/usb_ep_slot.sv
// Per-endpoint state: STALL, data toggles, IN-armed and OUT-full buffer ownership.
module usb_ep_slot #(
  parameter int unsigned CNT_W = 7,
  parameter bit          ISO   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             succ,
  input  logic             dir_in,
  input  logic             setup,
  input  logic [CNT_W-1:0] idx,
  input  logic             arm,
  input  logic [CNT_W-1:0] arm_len,
  input  logic             rel,
  input  logic             stall_set,
  input  logic             stall_clr,
  output logic             stall,
  output logic             tog_in,
  output logic             tog_out,
  output logic             in_busy,
  output logic [CNT_W-1:0] in_len,
  output logic             out_full,
  output logic             out_setup,
  output logic [CNT_W-1:0] out_len
);

  logic succ_setup;
  logic succ_in;
  logic succ_out;

  assign succ_setup = succ && setup;
  assign succ_in    = succ && !setup && dir_in;
  assign succ_out   = succ && !setup && !dir_in;

  // SETUP success outranks every application request on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall     <= 1'b0;
      tog_in    <= 1'b0;
      tog_out   <= 1'b0;
      in_busy   <= 1'b0;
      in_len    <= '0;
      out_full  <= 1'b0;
      out_setup <= 1'b0;
      out_len   <= '0;
    end else if (clr) begin
      stall     <= 1'b0;
      tog_in    <= 1'b0;
      tog_out   <= 1'b0;
      in_busy   <= 1'b0;
      in_len    <= '0;
      out_full  <= 1'b0;
      out_setup <= 1'b0;
      out_len   <= '0;
    end else begin
      if (succ_setup)     stall <= 1'b0;
      else if (stall_set) stall <= 1'b1;
      else if (stall_clr) stall <= 1'b0;

      if (succ_setup || succ_in) begin
        in_busy <= 1'b0;
      end else if (arm && !in_busy) begin
        in_busy <= 1'b1;
        in_len  <= arm_len;
      end

      if (succ_setup || succ_out) begin
        out_full  <= 1'b1;
        out_len   <= idx;
        out_setup <= succ_setup;
      end else if (rel) begin
        out_full  <= 1'b0;
        out_setup <= 1'b0;
      end

      // Isochronous endpoints keep DATA0 forever.
      if (succ_setup) begin
        tog_in  <= !ISO;
        tog_out <= !ISO;
      end else begin
        if (succ_in && !ISO)  tog_in  <= ~tog_in;
        if (succ_out && !ISO) tog_out <= ~tog_out;
      end
    end
  end

endmodule

// File: rtl/usb_ep_ctrl.sv
// Multi-endpoint controller between the USB protocol engine and application buffers.
// Optional isochronous support is compiled in with USB_EP_CTRL_ISO_EN.
module usb_ep_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned NUM_EP  = 4,
  parameter int unsigned MAX_PKT = 64,
`ifdef USB_EP_CTRL_ISO_EN
  parameter logic [NUM_EP-1:0] ISO_MASK = '0,
`endif
  localparam int unsigned IDX_W = $clog2(MAX_PKT),
  localparam int unsigned CNT_W = IDX_W + 1,
  localparam int unsigned EP_W  = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  localparam int unsigned AW    = 1 + EP_W + IDX_W
) (
  input  logic                    rst_n,
  input  logic                    clk_48,
  input  logic                    usb_rst,
  input  logic                    transaction_active,
  input  logic [3:0]              endpoint,
  input  logic                    direction_in,
  input  logic                    setup,
  input  logic [7:0]              data_out,
  input  logic                    data_strobe,
  input  logic                    success,
  output logic                    data_toggle,
  output logic [1:0]              handshake,
  output logic [7:0]              data_in,
  output logic                    data_in_valid,
  output logic [AW-1:0]           mem_raddr,
  input  logic [7:0]              mem_rdata,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_waddr,
  output logic [7:0]              mem_wdata,
  input  logic                    in_arm,
  input  logic [EP_W-1:0]         in_arm_ep,
  input  logic [CNT_W-1:0]        in_arm_len,
  input  logic                    out_release,
  input  logic [EP_W-1:0]         out_release_ep,
  input  logic [NUM_EP-1:0]       stall_set,
  input  logic [NUM_EP-1:0]       stall_clr,
  output logic [NUM_EP-1:0]       in_busy,
  output logic [NUM_EP-1:0]       out_full,
  output logic [NUM_EP-1:0]       out_setup,
  output logic [NUM_EP*CNT_W-1:0] out_len,
  output logic [NUM_EP-1:0]       ep_stalled
);

  logic [EP_W-1:0]   ep;
  logic              ep_valid;
  logic              ta_q;
  logic              start;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  idx_cur;
  logic              ovf;
  logic              out_dir;
  logic              succ_ok;
  logic              cur_iso;
  handshake_t        hs;
  logic              tog;
  logic              div;
  logic              we;
  logic [NUM_EP-1:0] tog_in_v;
  logic [NUM_EP-1:0] tog_out_v;
  logic [CNT_W-1:0]  in_len_a [NUM_EP];

  assign ep       = endpoint[EP_W-1:0];
  assign ep_valid = {1'b0, endpoint} < 5'(NUM_EP);
  assign start    = transaction_active && !ta_q;
  assign idx_cur  = start ? '0 : idx;
  assign out_dir  = setup || !direction_in;

`ifdef USB_EP_CTRL_ISO_EN
  assign cur_iso = ISO_MASK[ep];
`else
  assign cur_iso = 1'b0;
`endif

  // Byte index restarts on every token so a retry resends or rewrites from byte 0.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      ta_q <= 1'b0;
      idx  <= '0;
      ovf  <= 1'b0;
    end else if (usb_rst) begin
      ta_q <= 1'b0;
      idx  <= '0;
      ovf  <= 1'b0;
    end else begin
      ta_q <= transaction_active;
      if (start) begin
        idx <= '0;
        ovf <= 1'b0;
      end
      if (transaction_active && data_strobe) begin
        if (idx_cur < CNT_W'(MAX_PKT)) idx <= idx_cur + CNT_W'(1);
        else if (out_dir)              ovf <= 1'b1;
      end
    end
  end

  // Handshake, toggle and datapath strobes for the endpoint the engine is addressing.
  always_comb begin
    hs  = hs_nak;
    tog = 1'b0;
    div = 1'b0;
    we  = 1'b0;
    if (rst_n && !usb_rst) begin
      if (!ep_valid)            hs = hs_stall;
      else if (setup)           hs = ovf ? hs_nak : hs_ack;
      else if (ep_stalled[ep])  hs = hs_stall;
      else if (cur_iso)         hs = hs_none;
      else if (direction_in)    hs = in_busy[ep] ? hs_ack : hs_nak;
      else                      hs = (out_full[ep] || ovf) ? hs_nak : hs_ack;

      if (ep_valid && !setup && !cur_iso)
        tog = direction_in ? tog_in_v[ep] : tog_out_v[ep];

      div = ep_valid && direction_in && !setup && !ep_stalled[ep] &&
            in_busy[ep] && (idx_cur < in_len_a[ep]);

      // Never write into a buffer we are refusing, so a held packet stays intact.
      we = transaction_active && data_strobe && ep_valid && out_dir &&
           (idx_cur < CNT_W'(MAX_PKT)) && (hs == hs_ack || hs == hs_none);
    end
  end

  assign succ_ok       = success && ep_valid && !ovf && (hs == hs_ack || hs == hs_none);
  assign handshake     = hs;
  assign data_toggle   = tog;
  assign data_in_valid = div;
  assign data_in       = mem_rdata;
  assign mem_raddr     = {1'b1, ep, idx_cur[IDX_W-1:0]};
  assign mem_we        = we;
  assign mem_waddr     = {1'b0, ep, idx_cur[IDX_W-1:0]};
  assign mem_wdata     = data_out;

  for (genvar i = 0; i < NUM_EP; i++) begin : g_slot
`ifdef USB_EP_CTRL_ISO_EN
    localparam bit SLOT_ISO = ISO_MASK[i];
`else
    localparam bit SLOT_ISO = 1'b0;
`endif
    usb_ep_slot #(
      .CNT_W (CNT_W),
      .ISO   (SLOT_ISO)
    ) u_slot (
      .clk       (clk_48),
      .rst_n     (rst_n),
      .clr       (usb_rst),
      .succ      (succ_ok && (ep == EP_W'(i))),
      .dir_in    (direction_in),
      .setup     (setup),
      .idx       (idx),
      .arm       (in_arm && (in_arm_ep == EP_W'(i))),
      .arm_len   (in_arm_len),
      .rel       (out_release && (out_release_ep == EP_W'(i))),
      .stall_set (stall_set[i]),
      .stall_clr (stall_clr[i]),
      .stall     (ep_stalled[i]),
      .tog_in    (tog_in_v[i]),
      .tog_out   (tog_out_v[i]),
      .in_busy   (in_busy[i]),
      .in_len    (in_len_a[i]),
      .out_full  (out_full[i]),
      .out_setup (out_setup[i]),
      .out_len   (out_len[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/usb_ep_ctrl.md
Name: usb_ep_ctrl

Overview:
- Parametrised multi-endpoint controller between the USB protocol engine (`usb`) and application logic.
- Per endpoint it owns the IN/OUT data toggles, STALL state, IN-armed buffer and OUT-full buffer.
- It drives `handshake`/`data_toggle` back to the engine and moves payload bytes to/from a shared packet RAM.
- Replaces the single-endpoint, externally managed toggle/handshake scheme; adds buffer ownership, retry and overflow handling.

Parameters:
- NUM_EP, 4: endpoints 0..NUM_EP-1 (1..16).
- MAX_PKT, 64: max payload bytes per packet; power of two, 8..512.
- Derived: IDX_W=$clog2(MAX_PKT), CNT_W=IDX_W+1, EP_W=max(1,$clog2(NUM_EP)).

Ports:
- rst_n  in  1  async active-low reset
- clk_48  in  1  48 MHz clock
- usb_rst  in  1  bus reset from engine; synchronous clear of all state
- transaction_active  in  1  from engine
- endpoint  in  4  from engine
- direction_in  in  1  from engine
- setup  in  1  from engine
- data_out  in  8  received byte; valid while data_strobe is high
- data_strobe  in  1  from engine: byte consumed (IN) or byte delivered (OUT)
- success  in  1  from engine: transaction-complete pulse
- data_toggle  out  1  expected/sent toggle for the current transaction
- handshake  out  2  ack=00, none=01, nak=10, stall=11
- data_in  out  8  IN byte, equal to mem_rdata
- data_in_valid  out  1  another IN byte is available
- mem_raddr  out  1+EP_W+IDX_W  {1'b1, ep, idx}; RAM read is combinational
- mem_rdata  in  8  RAM read data
- mem_we  out  1  RAM write strobe
- mem_waddr  out  1+EP_W+IDX_W  {1'b0, ep, idx}
- mem_wdata  out  8  equals data_out
- in_arm  in  1  pulse: arm IN buffer in_arm_ep with in_arm_len bytes
- in_arm_ep  in  EP_W  IN endpoint to arm
- in_arm_len  in  CNT_W  byte count, 0..MAX_PKT
- out_release  in  1  pulse: give OUT buffer out_release_ep back to the host
- out_release_ep  in  EP_W  OUT endpoint to release
- stall_set  in  NUM_EP  per-endpoint set-STALL pulses
- stall_clr  in  NUM_EP  per-endpoint clear-STALL pulses
- in_busy  out  NUM_EP  IN buffer armed, not yet ACKed
- out_full  out  NUM_EP  OUT buffer holds an unreleased packet
- out_setup  out  NUM_EP  held packet came from a SETUP token
- out_len  out  NUM_EP*CNT_W  held packet length, ep0 in LSBs
- ep_stalled  out  NUM_EP  current STALL state

Behaviour:
- Reset (rst_n low) or usb_rst:
  - all per-endpoint bits 0, toggles DATA0, idx=0, ovf=0;
  - mem_we=0, handshake=nak, data_in_valid=0.
- Transaction start (rising edge of transaction_active): idx<=0, ovf<=0. A retry therefore resends or rewrites from byte 0.
- handshake (combinational):
  - endpoint>=NUM_EP: stall.
  - setup=1: ack.
  - ep_stalled: stall.
  - IN: in_busy ? ack : nak.
  - OUT: (out_full | ovf) ? nak : ack.
- data_toggle:
  - setup: 0.
  - IN: tog_in[ep].
  - OUT: tog_out[ep].
- IN phase:
  - data_in_valid = in_busy[ep] && idx<in_len[ep].
  - data_strobe increments idx.
  - in_arm_len=0 sends a zero-length packet.
- OUT/SETUP phase, on data_strobe:
  - idx<MAX_PKT: mem_we=1 same cycle, idx++.
  - idx==MAX_PKT: drop the byte, set ovf. Handshake becomes nak; no success, no state change.
- On success:
  - IN: clear in_busy, flip tog_in.
  - OUT: set out_full, out_len<=idx, out_setup<=0, flip tog_out.
  - SETUP: set out_full, out_setup<=1, out_len<=idx, tog_in<=1, tog_out<=1, clear in_busy and stall. SETUP overwrites a full buffer.
- Toggle mismatch: the engine ACKs without a success pulse, so no state changes.
- in_arm: ignored when in_busy[ep] is already set; otherwise sets in_busy and latches in_len.
- out_release: clears out_full and out_setup.
- Same cycle, same endpoint:
  - SETUP success beats stall_set.
  - stall_set beats stall_clr.
  - in_arm beats nothing; a same-cycle IN success leaves in_busy clear and in_arm is dropped.
- usb_rst mid-transaction aborts: no flips, no buffer changes.

Optional Feature:
- Macro USB_EP_CTRL_ISO_EN adds parameter ISO_MASK (NUM_EP bits, default 0).
- With the macro, endpoints whose ISO_MASK bit is set:
  - handshake none;
  - toggle fixed 0, never flipped;
  - IN with in_busy clear sends a zero-length packet;
  - OUT overwrites even when out_full.
- Without the macro: all endpoints are bulk/control; no ISO_MASK parameter.

Decomposition:
- Package usb_pkg, shared with `usb`:
  - hs_ack/hs_none/hs_nak/hs_stall;
  - handshake_t;
  - PID nibble constants.
- Sub-module usb_ep_slot, one generate instance per endpoint:
  - holds stall, tog_in, tog_out, in_busy, in_len, out_full, out_setup, out_len;
  - applies success/arm/release/stall priority rules.
- The top holds idx, ovf, muxing and memory addressing.

Test Plan:
- Arm ep1 with 3 bytes, IN token: data_in sequence RAM[1,1,0..2], then valid=0. Toggle 0. After success: in_busy[1]=0, next toggle 1.
- IN without success, then repeated IN: same 3 bytes resent, toggle still 0.
- OUT of 5 bytes to ep2: 5 mem_we at addr {0,2,0..4}, handshake ack. After success: out_full[2]=1, out_len=5. Next OUT gets nak until out_release.
- OUT of MAX_PKT+1 bytes: MAX_PKT writes, handshake nak, out_full stays 0, toggle unchanged.
- stall_set[0], then IN on ep0 gives stall. Then SETUP of 8 bytes gives ack, stall cleared, out_setup[0]=1, both toggles 1.
- IN token to endpoint NUM_EP gives stall. usb_rst clears all toggles and flags.
